// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache.
// Word-serial line refill, round-robin victim choice, set invalidate.
module icache_nway #(
    parameter int  WAYS       = 2,
    parameter int  SET_BITS   = 8,
    parameter int  LINE_WBITS = 2,
    localparam int TAG_W      = 32 - SET_BITS - LINE_WBITS - 2,
    localparam int OFF_W      = LINE_WBITS + 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                valid,
    input  logic                uncache,
    input  logic [TAG_W-1:0]    tag,
    input  logic [SET_BITS-1:0] index,
    input  logic [OFF_W-1:0]    offset,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [31:0]         rdata,
    input  logic                inv_valid,
    input  logic [SET_BITS-1:0] inv_index,
    output logic                inv_ok,
    output logic                rd_req,
    output logic                rd_type,
    output logic [31:0]         rd_addr,
    input  logic                rd_rdy,
    input  logic                ret_valid,
    input  logic                ret_last,
    input  logic [31:0]         ret_data
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int WORDS = 1 << LINE_WBITS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS, REFILL, WRITE, UREQ, URESP, INV
    } state_t;

    state_t                 state, state_nxt;
    logic [TAG_W-1:0]       rb_tag;
    logic [SET_BITS-1:0]    rb_index;
    logic [OFF_W-1:0]       rb_offset;
    logic [LINE_WBITS-1:0]  rb_word;
    logic [WAYS-1:0]        valid_bits [SETS];
    logic [WAY_W-1:0]       rr_ptr [SETS];
    logic [WAY_W-1:0]       rr_inc;
    logic [WAY_W-1:0]       victim, victim_nxt;
    logic                   victim_rr, victim_rr_nxt;
    logic [LINE_WBITS-1:0]  word_cnt;
    logic [WORDS-1:0][31:0] fill_buf;
    logic [WAYS-1:0]        hit_vec;
    logic [31:0]            way_word [WAYS];
    logic [31:0]            hit_word;
    logic                   hit, accept, mem_we;

    assign rb_word = rb_offset[OFF_W-1:2];
    assign hit     = |hit_vec;
    assign mem_we  = (state == WRITE);
    assign accept  = valid && !inv_valid &&
                     (state == IDLE || (state == LOOKUP && hit));
    assign addr_ok = accept;

    // Arrays are read on acceptance so tag/line are ready in LOOKUP.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TAG_W-1:0]       tag_mem [SETS];
        logic [WORDS-1:0][31:0] data_mem [SETS];
        logic [TAG_W-1:0]       tag_q;
        logic [WORDS-1:0][31:0] line_q;

        always_ff @(posedge clk) begin
            if (mem_we && victim == WAY_W'(w)) begin
                tag_mem[rb_index]  <= rb_tag;
                data_mem[rb_index] <= fill_buf;
            end
            if (accept) begin
                tag_q  <= tag_mem[index];
                line_q <= data_mem[index];
            end
        end

        assign hit_vec[w]  = valid_bits[rb_index][w] && (tag_q == rb_tag);
        assign way_word[w] = line_q[rb_word];
    end

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++)
            if (hit_vec[w]) hit_word = hit_word | way_word[w];
    end

    // Lowest invalid way wins; otherwise fall back to the set's pointer.
    always_comb begin
        victim_nxt    = rr_ptr[rb_index];
        victim_rr_nxt = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_bits[rb_index][w]) begin
                victim_nxt    = WAY_W'(w);
                victim_rr_nxt = 1'b0;
            end
        end
    end

    assign rr_inc = (rr_ptr[rb_index] == WAY_W'(WAYS - 1)) ?
                    '0 : rr_ptr[rb_index] + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rb_tag    <= '0;
            rb_index  <= '0;
            rb_offset <= '0;
            victim    <= '0;
            victim_rr <= 1'b0;
            word_cnt  <= '0;
            fill_buf  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_bits[s] <= '0;
                rr_ptr[s]     <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                rb_tag    <= tag;
                rb_index  <= index;
                rb_offset <= offset;
            end
            if (state == LOOKUP && !hit) begin
                victim    <= victim_nxt;
                victim_rr <= victim_rr_nxt;
            end
            if (state == MISS)
                word_cnt <= '0;
            if (state == REFILL && ret_valid) begin
                fill_buf[word_cnt] <= ret_data;
                word_cnt           <= word_cnt + 1'b1;
            end
            if (state == WRITE) begin
                valid_bits[rb_index][victim] <= 1'b1;
                if (victim_rr)
                    rr_ptr[rb_index] <= rr_inc;
            end
            if (state == INV)
                valid_bits[inv_index] <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        data_ok   = 1'b0;
        rdata     = '0;
        inv_ok    = 1'b0;
        rd_req    = 1'b0;
        rd_type   = 1'b0;
        rd_addr   = '0;
        unique case (state)
            IDLE: begin
                if (inv_valid)
                    state_nxt = INV;
                else if (accept)
                    state_nxt = uncache ? UREQ : LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    data_ok = 1'b1;
                    rdata   = hit_word;
                    if (accept)
                        state_nxt = uncache ? UREQ : LOOKUP;
                    else
                        state_nxt = IDLE;
                end else begin
                    state_nxt = MISS;
                end
            end
            MISS: begin
                rd_req  = 1'b1;
                rd_type = 1'b1;
                rd_addr = {rb_tag, rb_index, {OFF_W{1'b0}}};
                if (rd_rdy)
                    state_nxt = REFILL;
            end
            REFILL: begin
                if (ret_valid && ret_last)
                    state_nxt = WRITE;
            end
            WRITE: begin
                data_ok   = 1'b1;
                rdata     = fill_buf[rb_word];
                state_nxt = IDLE;
            end
            UREQ: begin
                rd_req  = 1'b1;
                rd_addr = {rb_tag, rb_index, rb_offset};
                if (rd_rdy)
                    state_nxt = URESP;
            end
            URESP: begin
                if (ret_valid) begin
                    data_ok   = 1'b1;
                    rdata     = ret_data;
                    state_nxt = IDLE;
                end
            end
            INV: begin
                inv_ok    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway with a behavioural AXI-bridge model.
// Expected words come from the bench's own memory function.
module tb_icache_nway;

    localparam int TAG_W     = 20;
    localparam int WORDS     = 4;
    localparam int MISS_LAT  = 7;
    localparam int SHORT_LAT = 5;
    localparam int UNC_LAT   = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid, uncache;
    logic [19:0] tag;
    logic [7:0]  index;
    logic [3:0]  offset;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        inv_valid;
    logic [7:0]  inv_index;
    logic        inv_ok;
    logic        rd_req, rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy, ret_valid, ret_last;
    logic [31:0] ret_data;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          br_cnt = 0;
    int          br_n;
    int          beat_idx = -1;
    int          last_wait;
    int          n;
    logic [31:0] br_addr;
    logic        br_type;
    logic        short_burst;

    icache_nway dut (
        .clk(clk), .resetn(resetn),
        .valid(valid), .uncache(uncache),
        .tag(tag), .index(index), .offset(offset),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .inv_valid(inv_valid), .inv_index(inv_index), .inv_ok(inv_ok),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid),
        .ret_last(ret_last), .ret_data(ret_data)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:4] == 28'h1FC0000) return 32'hA0 | {28'h0, 2'b00, w[3:2]};
        if (w == 32'hBFC00100) return 32'h3C08BFC0;
        return w ^ 32'h5EED0000;
    endfunction

    // Bridge: accepts immediately, then streams beats one per cycle.
    initial begin
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
        forever begin
            @(negedge clk);
            ret_valid = 0; ret_last = 0; rd_rdy = 0; beat_idx = -1;
            if (rd_req) begin
                rd_rdy  = 1;
                br_addr = rd_addr;
                br_type = rd_type;
                br_cnt++;
                br_n = rd_type ? (short_burst ? 2 : WORDS) : 1;
                for (int i = 0; i < br_n; i++) begin
                    @(negedge clk);
                    rd_rdy    = 0;
                    beat_idx  = i;
                    ret_valid = 1;
                    ret_data  = model(br_addr + 32'(4 * i));
                    ret_last  = (i == br_n - 1);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #4;
        if (data_ok) begin
            chk("single_way_hit", 32'($countones(dut.hit_vec) > 1), 0);
            if (exp_q.size() == 0) begin
                chk("spurious_data_ok", data_ok, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", rdata, mon_e.data);
                chk("latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic req(input logic unc, input logic [TAG_W-1:0] t,
                       input logic [7:0] i, input logic [3:0] o,
                       input int lat);
        exp_t e;
        int   k = 0;
        valid = 1; uncache = unc; tag = t; index = i; offset = o;
        #4;
        while (!addr_ok && k < 50) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (!addr_ok) begin
            chk("accept_timeout", addr_ok, 1);
        end else begin
            e.data = model({t, i, o});
            e.lat  = lat;
            e.acc  = cyc;
            exp_q.push_back(e);
        end
        last_wait = k;
        @(negedge clk);
        valid = 0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic fetch(input logic unc, input logic [TAG_W-1:0] t,
                         input logic [7:0] i, input logic [3:0] o,
                         input int lat);
        req(unc, t, i, o, lat);
        drain();
    endtask

    task automatic chk_idle_outs(input string pfx);
        chk({pfx, "_addr_ok"}, addr_ok, 0);
        chk({pfx, "_data_ok"}, data_ok, 0);
        chk({pfx, "_rdata"}, rdata, 0);
        chk({pfx, "_inv_ok"}, inv_ok, 0);
        chk({pfx, "_rd_req"}, rd_req, 0);
        chk({pfx, "_rd_type"}, rd_type, 0);
        chk({pfx, "_rd_addr"}, rd_addr, 0);
    endtask

    initial begin
        resetn = 0; valid = 0; uncache = 0;
        tag = '0; index = '0; offset = '0;
        inv_valid = 0; inv_index = '0; short_burst = 0;
        repeat (3) @(negedge clk);
        #4;
        chk_idle_outs("reset");
        @(negedge clk);
        resetn = 1;
        @(negedge clk);

        fetch(0, 20'h1FC00, 8'h00, 4'h4, MISS_LAT);
        chk("cold_rd_addr", br_addr, 32'h1FC00000);
        chk("cold_rd_type", br_type, 1);
        chk("cold_reqs", br_cnt, 1);
        fetch(0, 20'h1FC00, 8'h00, 4'hC, 1);
        chk("hit_no_req", br_cnt, 1);

        req(0, 20'h1FC00, 8'h00, 4'h0, 1);
        chk("b2b_acc0", last_wait, 0);
        req(0, 20'h1FC00, 8'h00, 4'h4, 1);
        chk("b2b_acc1", last_wait, 0);
        req(0, 20'h1FC00, 8'h00, 4'h8, 1);
        chk("b2b_acc2", last_wait, 0);
        drain();
        chk("b2b_no_req", br_cnt, 1);

        fetch(0, 20'h00100, 8'h05, 4'h0, MISS_LAT);
        fetch(0, 20'h00200, 8'h05, 4'h4, MISS_LAT);
        fetch(0, 20'h00100, 8'h05, 4'h8, 1);
        fetch(0, 20'h00300, 8'h05, 4'h0, MISS_LAT);
        fetch(0, 20'h00200, 8'h05, 4'h0, 1);
        fetch(0, 20'h00400, 8'h05, 4'hC, MISS_LAT);
        fetch(0, 20'h00300, 8'h05, 4'h4, 1);
        fetch(0, 20'h00200, 8'h05, 4'h8, MISS_LAT);
        fetch(0, 20'h00400, 8'h05, 4'h0, 1);

        fetch(1, 20'hBFC00, 8'h10, 4'h0, UNC_LAT);
        chk("unc_rd_type", br_type, 0);
        chk("unc_rd_addr", br_addr, 32'hBFC00100);
        fetch(0, 20'hBFC00, 8'h10, 4'h4, MISS_LAT);
        chk("after_unc_type", br_type, 1);
        chk("after_unc_addr", br_addr, 32'hBFC00100);

        inv_valid = 1; inv_index = 8'h05;
        valid = 1; uncache = 0; tag = 20'h00400; index = 8'h05; offset = 4'h0;
        #4;
        chk("inv_prio_addr_ok", addr_ok, 0);
        n = 0;
        while (!inv_ok && n < 20) begin
            @(negedge clk);
            #4;
            n++;
        end
        chk("inv_ok_seen", inv_ok, 1);
        chk("inv_lat", n, 1);
        chk("inv_addr_ok", addr_ok, 0);
        @(negedge clk);
        inv_valid = 0; valid = 0;
        @(negedge clk);
        fetch(0, 20'h00400, 8'h05, 4'h0, MISS_LAT);
        fetch(0, 20'h1FC00, 8'h00, 4'h8, 1);

        short_burst = 1;
        fetch(0, 20'h00777, 8'h33, 4'h4, SHORT_LAT);
        short_burst = 0;
        fetch(0, 20'h00777, 8'h33, 4'h0, 1);

        req(0, 20'h0ABCD, 8'h21, 4'h8, MISS_LAT);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(ret_valid && beat_idx == 1) && n < 50);
        chk("rst_beat_seen", ret_valid, 1);
        resetn = 0;
        #1;
        chk_idle_outs("mid_rst");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        repeat (4) @(negedge clk);
        fetch(0, 20'h0ABCD, 8'h21, 4'h8, MISS_LAT);
        fetch(0, 20'h1FC00, 8'h00, 4'h0, MISS_LAT);
        fetch(0, 20'h1FC00, 8'h00, 4'h4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
